// File: rtl/idct8x8_2d_block_ts.sv
// 2-D 8x8 inverse DCT on whole coefficient blocks: a row pass then a column pass,
// both sharing one 8-multiplier MAC that produces one sample per clock.
module idct8x8_2d_block_ts #(
  parameter int IN_W    = 32,
  parameter int FRAC    = 8,
  parameter int CONST_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [64*IN_W-1:0] in_block,
  output logic               in_ready,
  output logic               out_valid,
  output logic [64*IN_W-1:0] out_block,
  input  logic               out_ready,
  output logic               busy
);

  localparam int PROD_W = IN_W + CONST_W;
  localparam int SUM_W  = PROD_W + 3;

  // K[k][n] = round(c(k)/2 * cos((2n+1)k*pi/16) * 2^8), k-major
  localparam int K_TAB [64] = '{
     91,   91,   91,   91,   91,   91,   91,   91,
    126,  106,   71,   25,  -25,  -71, -106, -126,
    118,   49,  -49, -118, -118,  -49,   49,  118,
    106,  -25, -126,  -71,   71,  126,   25, -106,
     91,  -91,  -91,   91,   91,  -91,  -91,   91,
     71, -126,   25,  106, -106,  -25,  126,  -71,
     49, -118,  118,  -49,  -49,  118, -118,   49,
     25,  -71,  106, -126,  126, -106,   71,  -25
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROW  = 2'd1,
    S_COL  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                   state_r, state_next_s;
  logic [5:0]               idx_r;
  logic                     in_ready_r, out_valid_r, busy_r;
  logic signed [IN_W-1:0]   coef_mem [64];
  logic signed [IN_W-1:0]   row_mem  [64];
  logic signed [IN_W-1:0]   pix_mem  [64];

  logic [2:0]               v_s, n_s;
  logic signed [IN_W-1:0]   opnd_s   [8];
  logic signed [CONST_W-1:0] kc_s    [8];
  logic signed [PROD_W-1:0] prod_s   [8];
  logic signed [SUM_W-1:0]  acc_s, rnd_s, shr_s;
  logic signed [IN_W-1:0]   mac_out_s;

  function automatic logic signed [IN_W-1:0] sat_in(input logic signed [SUM_W-1:0] val);
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    hi = SUM_W'({1'b0, {(IN_W-1){1'b1}}});
    lo = ~hi;
    if (val > hi) begin
      sat_in = {1'b0, {(IN_W-1){1'b1}}};
    end else if (val < lo) begin
      sat_in = {1'b1, {(IN_W-1){1'b0}}};
    end else begin
      sat_in = val[IN_W-1:0];
    end
  endfunction

  assign v_s = idx_r[5:3];
  assign n_s = idx_r[2:0];

  // Shared MAC: row pass reads a coefficient row, column pass reads a row_mem column
  always_comb begin
    opnd_s = '{default: '0};
    kc_s   = '{default: '0};
    prod_s = '{default: '0};
    acc_s  = '0;
    for (int k = 0; k < 8; k++) begin
      if (state_r == S_COL) begin
        opnd_s[k] = row_mem[k*8 + int'(v_s)];
      end else begin
        opnd_s[k] = coef_mem[int'(v_s)*8 + k];
      end
      kc_s[k]   = CONST_W'(K_TAB[k*8 + int'(n_s)]);
      prod_s[k] = PROD_W'(opnd_s[k]) * PROD_W'(kc_s[k]);
      acc_s     = acc_s + SUM_W'(prod_s[k]);
    end
    rnd_s     = acc_s + SUM_W'(2**(FRAC-1));
    shr_s     = rnd_s >>> FRAC;
    mac_out_s = sat_in(shr_s);
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) state_next_s = S_ROW;
        else          state_next_s = S_IDLE;
      end
      S_ROW: begin
        if (idx_r == 6'd63) state_next_s = S_COL;
        else                state_next_s = S_ROW;
      end
      S_COL: begin
        if (idx_r == 6'd63) state_next_s = S_OUT;
        else                state_next_s = S_COL;
      end
      S_OUT: begin
        if (out_ready) state_next_s = S_IDLE;
        else           state_next_s = S_OUT;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State, sample index and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      idx_r       <= 6'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == S_IDLE);
      out_valid_r <= (state_next_s == S_OUT);
      busy_r      <= (state_next_s == S_ROW) || (state_next_s == S_COL);
      case (state_r)
        S_IDLE:  idx_r <= 6'd0;
        S_ROW:   idx_r <= idx_r + 6'd1;
        S_COL:   idx_r <= idx_r + 6'd1;
        S_OUT:   idx_r <= 6'd0;
        default: idx_r <= 6'd0;
      endcase
    end
  end

  // Block memories; column results land transposed so pix_mem is raster order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        coef_mem[i] <= '0;
        row_mem[i]  <= '0;
        pix_mem[i]  <= '0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 64; i++) coef_mem[i] <= in_block[i*IN_W +: IN_W];
          end
        end
        S_ROW:   row_mem[idx_r] <= mac_out_s;
        S_COL:   pix_mem[{n_s, v_s}] <= mac_out_s;
        S_OUT:   ;
        default: ;
      endcase
    end
  end

  // Flatten the pixel memory onto the output bus
  always_comb begin
    out_block = '0;
    for (int i = 0; i < 64; i++) out_block[i*IN_W +: IN_W] = pix_mem[i];
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule
